// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Port ids, arbitration policy codes and the request bundle.
package mem_arb_pkg;

    localparam int ARB_AW    = 11;
    localparam int ARB_DW    = 32;
    localparam int ARB_BYTES = ARB_DW / 8;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef logic port_id_t;

    typedef struct packed {
        logic [ARB_AW-1:0]    addr;
        logic [ARB_DW-1:0]    wdata;
        logic [ARB_BYTES-1:0] wen;
    } mem_req_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry first-word-fall-through response FIFO.
// Output data comes straight from registers and holds while not popped.
module mem_rsp_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [1:0]            count_q, count_d;
    logic                  pop;

    assign valid_o = (count_q != 2'd0);
    assign pop     = pop_i & valid_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_comb begin
        wr_d    = wr_q ^ push_i;
        rd_d    = rd_q ^ pop;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // When full, a same-cycle pop frees exactly the slot being written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop && count_q == 2'd2));

endmodule

// File: rtl/mem_sp_arbiter.sv
// Two-port arbiter/sequencer for a 1-cycle-latency single-port memory.
// Port 0 is instruction fetch, port 1 is data; reads return via per-port FIFOs.
module mem_sp_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int PRIO_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_p0_req_valid,
    output logic                  o_p0_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    input  logic [DATA_BYTES-1:0] i_p0_wen,
    output logic                  o_p0_rsp_valid,
    input  logic                  i_p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_p0_rsp_rdata,
    input  logic                  i_p1_req_valid,
    output logic                  o_p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    input  logic [DATA_BYTES-1:0] i_p1_wen,
    output logic                  o_p1_rsp_valid,
    input  logic                  i_p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_p1_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_BYTES-1:0] wen;
    } req_t;

    logic     inflight_q, inflight_d;
    port_id_t inflight_port_q, inflight_port_d;
    port_id_t ptr_q, ptr_d;

    logic [1:0] cnt0, cnt1;
    logic       pop0, pop1;
    logic       push0, push1;
    logic [2:0] used0, used1;
    logic [1:0] elig;
    logic       gnt_any;
    port_id_t   gnt_port;
    req_t       req0, req1, sel;

    assign req0 = '{addr: i_p0_addr, wdata: i_p0_wdata, wen: i_p0_wen};
    assign req1 = '{addr: i_p1_addr, wdata: i_p1_wdata, wen: i_p1_wen};

    assign pop0  = o_p0_rsp_valid & i_p0_rsp_ready;
    assign pop1  = o_p1_rsp_valid & i_p1_rsp_ready;
    assign push0 = inflight_q & (inflight_port_q == 1'b0);
    assign push1 = inflight_q & (inflight_port_q == 1'b1);

    // Read credits: queued + in flight - leaving this cycle must stay below 2.
    assign used0 = {1'b0, cnt0} + {2'b0, push0} - {2'b0, pop0};
    assign used1 = {1'b0, cnt1} + {2'b0, push1} - {2'b0, pop1};

    assign elig[0] = rst_n & i_p0_req_valid & ((|i_p0_wen) | (used0 < 3'd2));
    assign elig[1] = rst_n & i_p1_req_valid & ((|i_p1_wen) | (used1 < 3'd2));

    always_comb begin
        gnt_any  = 1'b1;
        gnt_port = 1'b0;
        unique case (elig)
            2'b11:   gnt_port = (PRIO_MODE == PRIO_FIXED) ? 1'b1 : ptr_q;
            2'b10:   gnt_port = 1'b1;
            2'b01:   gnt_port = 1'b0;
            default: gnt_any  = 1'b0;
        endcase
    end

    always_comb begin
        ptr_d           = (elig == 2'b11) ? ~gnt_port : ptr_q;
        sel             = gnt_port ? req1 : req0;
        inflight_d      = gnt_any & ~(|sel.wen);
        inflight_port_d = gnt_port;
    end

    always_comb begin
        o_p0_req_ready = gnt_any & (gnt_port == 1'b0);
        o_p1_req_ready = gnt_any & (gnt_port == 1'b1);
        o_mem_addr     = i_p0_addr;
        o_mem_wdata    = '0;
        o_mem_wen      = '0;
        if (gnt_any) begin
            o_mem_addr  = sel.addr;
            o_mem_wdata = sel.wdata;
            o_mem_wen   = sel.wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_port_q <= 1'b0;
            ptr_q           <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_port_q <= inflight_port_d;
            ptr_q           <= ptr_d;
        end
    end

    mem_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push0),
        .push_data_i (i_mem_rdata),
        .pop_i       (i_p0_rsp_ready),
        .valid_o     (o_p0_rsp_valid),
        .data_o      (o_p0_rsp_rdata),
        .count_o     (cnt0)
    );

    mem_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push1),
        .push_data_i (i_mem_rdata),
        .pop_i       (i_p1_rsp_ready),
        .valid_o     (o_p1_rsp_valid),
        .data_o      (o_p1_rsp_rdata),
        .count_o     (cnt1)
    );

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Randomized bench for mem_sp_arbiter: round-robin and fixed-priority instances,
// each behind its own memory, against a queue-based reference model.
module tb_mem_sp_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_mem = 1'b1;
    always #5 clk = ~clk;

    logic        req_v   [2][2];
    logic        req_rdy [2][2];
    logic        rsp_v   [2][2];
    logic        rsp_rdy [2][2];
    logic [10:0] addr    [2][2];
    logic [31:0] wdata   [2][2];
    logic [31:0] rdata   [2][2];
    logic [3:0]  wen     [2][2];
    logic [10:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [3:0]  m_wen   [2];

    mem_sp_arbiter #(.PRIO_MODE(PRIO_RR)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i_p0_req_valid(req_v[0][0]), .o_p0_req_ready(req_rdy[0][0]),
        .i_p0_addr(addr[0][0]), .i_p0_wdata(wdata[0][0]), .i_p0_wen(wen[0][0]),
        .o_p0_rsp_valid(rsp_v[0][0]), .i_p0_rsp_ready(rsp_rdy[0][0]),
        .o_p0_rsp_rdata(rdata[0][0]),
        .i_p1_req_valid(req_v[0][1]), .o_p1_req_ready(req_rdy[0][1]),
        .i_p1_addr(addr[0][1]), .i_p1_wdata(wdata[0][1]), .i_p1_wen(wen[0][1]),
        .o_p1_rsp_valid(rsp_v[0][1]), .i_p1_rsp_ready(rsp_rdy[0][1]),
        .o_p1_rsp_rdata(rdata[0][1]),
        .o_mem_addr(m_addr[0]), .o_mem_wdata(m_wdata[0]), .o_mem_wen(m_wen[0]),
        .i_mem_rdata(m_rdata[0])
    );

    mem_sp_arbiter #(.PRIO_MODE(PRIO_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .i_p0_req_valid(req_v[1][0]), .o_p0_req_ready(req_rdy[1][0]),
        .i_p0_addr(addr[1][0]), .i_p0_wdata(wdata[1][0]), .i_p0_wen(wen[1][0]),
        .o_p0_rsp_valid(rsp_v[1][0]), .i_p0_rsp_ready(rsp_rdy[1][0]),
        .o_p0_rsp_rdata(rdata[1][0]),
        .i_p1_req_valid(req_v[1][1]), .o_p1_req_ready(req_rdy[1][1]),
        .i_p1_addr(addr[1][1]), .i_p1_wdata(wdata[1][1]), .i_p1_wen(wen[1][1]),
        .o_p1_rsp_valid(rsp_v[1][1]), .i_p1_rsp_ready(rsp_rdy[1][1]),
        .o_p1_rsp_rdata(rdata[1][1]),
        .o_mem_addr(m_addr[1]), .o_mem_wdata(m_wdata[1]), .o_mem_wen(m_wen[1]),
        .i_mem_rdata(m_rdata[1])
    );

    function automatic logic [31:0] pat(int d, int a);
        return (32'(a) * 32'h0001_0001) ^ ((d != 0) ? 32'h5A5A_0000 : 32'hC300_0000);
    endfunction

    logic [31:0] tmem [2][2048];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (init_mem) begin
                for (int a = 0; a < 2048; a++) tmem[d][a] <= pat(d, a);
            end else begin
                m_rdata[d] <= tmem[d][m_addr[d]];
                for (int b = 0; b < 4; b++)
                    if (m_wen[d][b]) tmem[d][m_addr[d]][8*b +: 8] <= m_wdata[d][8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic [31:0] ref_mem [2][2048];
    rsp_t        q0[$];
    rsp_t        q1[$];
    int          rr_ptr;
    int          cyc;
    int          d;

    logic        cv[2];
    logic [10:0] ca[2];
    logic [31:0] cd[2];
    logic [3:0]  cw[2];
    logic        crr[2];
    logic        last_acc[2];
    logic        rand_en[2];
    int          vprob[2], wprob[2], rprob[2], fix[2];
    mem_req_t    dq0[$];
    mem_req_t    dq1[$];
    int          gcnt[2], orc[2];
    logic [31:0] last_rsp[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic pick(int p);
        mem_req_t r;
        if (p == 0 && dq0.size() > 0) begin
            r = dq0.pop_front();
            cv[p] = 1'b1; ca[p] = r.addr; cd[p] = r.wdata; cw[p] = r.wen;
        end else if (p == 1 && dq1.size() > 0) begin
            r = dq1.pop_front();
            cv[p] = 1'b1; ca[p] = r.addr; cd[p] = r.wdata; cw[p] = r.wen;
        end else if (rand_en[p] && $urandom_range(99) < vprob[p]) begin
            cv[p] = 1'b1;
            if (fix[p] >= 0) ca[p] = 11'(fix[p]);
            else if ($urandom_range(7) == 0) ca[p] = 11'h7FF;
            else ca[p] = 11'($urandom_range(15));
            cd[p] = $urandom;
            cw[p] = ($urandom_range(99) < wprob[p]) ? 4'($urandom_range(15, 1)) : 4'h0;
        end else begin
            cv[p] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (!cv[p] || last_acc[p]) pick(p);
            crr[p] = ($urandom_range(99) < rprob[p]);
            req_v[d][p] = cv[p]; addr[d][p] = ca[p];
            wdata[d][p] = cd[p]; wen[d][p] = cw[p]; rsp_rdy[d][p] = crr[p];
            req_v[1-d][p] = 1'b0; addr[1-d][p] = '0;
            wdata[1-d][p] = '0; wen[1-d][p] = '0; rsp_rdy[1-d][p] = 1'b1;
        end
    endtask

    task automatic eval();
        logic ev[2], pop[2], el[2];
        int   qs[2];
        logic g;
        int   w;
        rsp_t f[2];
        rsp_t n;
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                check("rst_req_ready", 32'(req_rdy[d][p]), 32'd0);
                check("rst_rsp_valid", 32'(rsp_v[d][p]), 32'd0);
                last_acc[p] = 1'b0;
            end
            check("rst_mem_wen", 32'(m_wen[d]), 32'd0);
            q0.delete(); q1.delete(); rr_ptr = 0;
            cyc++;
            return;
        end
        qs[0] = q0.size(); qs[1] = q1.size();
        if (qs[0] > 0) f[0] = q0[0];
        if (qs[1] > 0) f[1] = q1[0];
        for (int p = 0; p < 2; p++) begin
            ev[p] = (qs[p] > 0) && (f[p].due <= cyc);
            check($sformatf("p%0d_rsp_valid", p), 32'(rsp_v[d][p]), 32'(ev[p]));
            if (ev[p]) check($sformatf("p%0d_rdata", p), rdata[d][p], f[p].data);
            pop[p] = ev[p] && crr[p];
            el[p]  = cv[p] && (cw[p] != 4'h0 || (qs[p] - int'(pop[p])) < 2);
        end
        g = el[0] || el[1];
        if (el[0] && el[1]) w = (d == 1) ? 1 : rr_ptr;
        else w = el[1] ? 1 : 0;
        check("p0_req_ready", 32'(req_rdy[d][0]), 32'(g && w == 0));
        check("p1_req_ready", 32'(req_rdy[d][1]), 32'(g && w == 1));
        check("mem_wen", 32'(m_wen[d]), g ? 32'(cw[w]) : 32'd0);
        check("mem_addr", 32'(m_addr[d]), g ? 32'(ca[w]) : 32'(ca[0]));
        check("mem_wdata", m_wdata[d], g ? cd[w] : 32'd0);
        for (int p = 0; p < 2; p++) begin
            if (rsp_v[d][p] && crr[p]) begin
                orc[p]++;
                last_rsp[p] = rdata[d][p];
            end
            if (req_rdy[d][p]) gcnt[p]++;
            last_acc[p] = req_rdy[d][p];
        end
        if (pop[0]) void'(q0.pop_front());
        if (pop[1]) void'(q1.pop_front());
        if (g) begin
            if (cw[w] != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (cw[w][b]) ref_mem[d][ca[w]][8*b +: 8] = cd[w][8*b +: 8];
            end else begin
                n.data = ref_mem[d][ca[w]];
                n.due  = cyc + 2;
                if (w == 0) q0.push_back(n);
                else q1.push_back(n);
            end
            if (el[0] && el[1]) rr_ptr = 1 - w;
        end
        cyc++;
    endtask

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            drive();
            @(negedge clk);
            eval();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic knobs(logic en, int vp, int wp, int rp, int f0, int f1);
        for (int p = 0; p < 2; p++) begin
            rand_en[p] = en; vprob[p] = vp; wprob[p] = wp; rprob[p] = rp;
        end
        fix[0] = f0; fix[1] = f1;
    endtask

    int g0, g1, o0, o1;

    initial begin
        cyc = 0; d = 0; rr_ptr = 0;
        for (int dd = 0; dd < 2; dd++)
            for (int a = 0; a < 2048; a++) ref_mem[dd][a] = pat(dd, a);
        for (int p = 0; p < 2; p++) begin
            cv[p] = 1'b0; ca[p] = '0; cd[p] = '0; cw[p] = '0; crr[p] = 1'b1;
            last_acc[p] = 1'b0; gcnt[p] = 0; orc[p] = 0; last_rsp[p] = '0;
        end
        knobs(1'b0, 0, 0, 100, -1, -1);
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        step(2);
        rst_n = 1'b1;

        // Write then read on port 1.
        o0 = orc[0];
        dq1.push_back('{addr: 11'h005, wdata: 32'hDEADBEEF, wen: 4'hF});
        dq1.push_back('{addr: 11'h005, wdata: 32'h0, wen: 4'h0});
        step(6);
        check("wr_rd_p1_data", last_rsp[1], 32'hDEADBEEF);
        check("wr_rd_p0_none", 32'(orc[0] - o0), 32'd0);

        // Byte-lane write merge.
        dq0.push_back('{addr: 11'h7FF, wdata: 32'h11223344, wen: 4'hF});
        dq0.push_back('{addr: 11'h7FF, wdata: 32'h00AA0000, wen: 4'b0100});
        dq0.push_back('{addr: 11'h7FF, wdata: 32'h0, wen: 4'h0});
        step(7);
        check("byte_merge", last_rsp[0], 32'h11AA3344);

        // Contested reads alternate.
        knobs(1'b1, 100, 0, 100, 'h010, 'h020);
        g0 = gcnt[0]; g1 = gcnt[1];
        step(20);
        check("rr_p0_grants", 32'(gcnt[0] - g0), 32'd10);
        check("rr_p1_grants", 32'(gcnt[1] - g1), 32'd10);
        knobs(1'b0, 0, 0, 100, -1, -1);
        step(4);

        // Response backpressure limits port 0 to two outstanding reads.
        rprob[0] = 0;
        g0 = gcnt[0]; o0 = orc[0];
        for (int a = 0; a < 4; a++) dq0.push_back('{addr: 11'(a), wdata: 32'h0, wen: 4'h0});
        step(6);
        check("bp_accepted", 32'(gcnt[0] - g0), 32'd2);
        rprob[0] = 100;
        step(10);
        check("bp_all_accepted", 32'(gcnt[0] - g0), 32'd4);
        check("bp_all_returned", 32'(orc[0] - o0), 32'd4);

        // Random mix on the round-robin instance.
        knobs(1'b1, 70, 40, 70, -1, -1);
        step(1500);
        knobs(1'b0, 0, 0, 100, -1, -1);
        step(6);

        // Reset the cycle after a read grant.
        o0 = orc[0];
        dq0.push_back('{addr: 11'h010, wdata: 32'h0, wen: 4'h0});
        step(1);
        rst_n = 1'b0;
        cv[0] = 1'b0; cv[1] = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        check("rst_drop_rsp", 32'(orc[0] - o0), 32'd0);
        dq0.push_back('{addr: 11'h030, wdata: 32'h0, wen: 4'h0});
        dq1.push_back('{addr: 11'h031, wdata: 32'h0, wen: 4'h0});
        step(1);
        check("post_rst_p0_wins", 32'(last_acc[0]), 32'd1);
        check("post_rst_p1_waits", 32'(last_acc[1]), 32'd0);
        step(6);

        // Fixed-priority instance.
        d = 1;
        knobs(1'b1, 100, 0, 100, 'h040, 'h041);
        g0 = gcnt[0]; g1 = gcnt[1];
        step(30);
        check("fx_p0_starved", 32'(gcnt[0] - g0), 32'd0);
        check("fx_p1_grants", 32'(gcnt[1] - g1), 32'd30);
        vprob[1] = 0;
        g0 = gcnt[0];
        step(10);
        check("fx_p0_after", 32'(gcnt[0] - g0 > 0), 32'd1);
        knobs(1'b1, 70, 40, 70, -1, -1);
        step(400);
        knobs(1'b0, 0, 0, 100, -1, -1);
        step(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_sp_arbiter.md
Name: mem_sp_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the synchronous single-port memory (mem_sync_sp_syn, 2048x32, byte write enables, 1-cycle read latency).
- Port 0 carries instruction fetch; port 1 carries data load/store.
- Accepts at most one request per cycle and drives the memory address, write-data and write-enable lines.
- Tracks in-flight reads and returns read data to the originating port through a per-port 2-entry response FIFO. Response backpressure never loses data.

Parameters:
- ADDR_WIDTH, 11: word address width. It matches a memory DEPTH of 2048.
- DATA_WIDTH, 32: data width.
- DATA_BYTES, DATA_WIDTH/8: number of byte write enables.
- PRIO_MODE, 0: arbitration policy. 0 selects round-robin; 1 gives port 1 fixed priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_p0_req_valid / i_p1_req_valid  in  1  request valid.
- o_p0_req_ready / o_p1_req_ready  out  1  request accepted this cycle.
- i_p0_addr / i_p1_addr  in  ADDR_WIDTH  word address.
- i_p0_wdata / i_p1_wdata  in  DATA_WIDTH  write data.
- i_p0_wen / i_p1_wen  in  DATA_BYTES  byte write enables. All zero means read.
- o_p0_rsp_valid / o_p1_rsp_valid  out  1  read data valid.
- i_p0_rsp_ready / i_p1_rsp_ready  in  1  requester takes the response.
- o_p0_rsp_rdata / o_p1_rsp_rdata  out  DATA_WIDTH  read data.
- o_mem_addr  out  ADDR_WIDTH  to memory i_addr.
- o_mem_wdata  out  DATA_WIDTH  to memory i_wdata.
- o_mem_wen  out  DATA_BYTES  to memory i_wen.
- i_mem_rdata  in  DATA_WIDTH  from memory o_rdata.

Behaviour:
- Reset, while rst_n is low:
  - o_pX_req_ready = 0, o_mem_wen = 0, o_pX_rsp_valid = 0.
  - Both FIFOs empty, in-flight flag clear, round-robin pointer points at port 0.
  - Reset mid-operation drops in-flight reads and queued responses; no response is issued for them.
- Eligibility of port p in a cycle:
  - Writes (wen != 0) are always eligible.
  - A read is eligible only if fifo_count_p + inflight_p - pop_p < 2, where pop_p = rsp_valid_p & rsp_ready_p.
  - The credit check guarantees FIFO space on arrival and sustains 1 read/cycle under continuous rsp_ready.
- Grant:
  - Exactly one eligible valid port is granted per cycle. Ready is combinational: o_pX_req_ready = grant_X.
  - PRIO_MODE=0: a single requester wins. If both request, the port named by the pointer wins; the pointer then moves to the other port. The pointer changes only on a contested grant.
  - PRIO_MODE=1: port 1 always wins a conflict.
- Memory drive (combinational from the granted request):
  - o_mem_addr, o_mem_wdata, o_mem_wen = granted port's values.
  - No grant: o_mem_wen = 0, o_mem_addr = i_p0_addr, o_mem_wdata = 0.
- Read pipeline:
  - Cycle N: grant and address presented.
  - Edge N→N+1: in-flight register set, recording the port id.
  - Cycle N+1: i_mem_rdata valid; pushed into that port's FIFO at the end of N+1.
  - o_pX_rsp_valid rises at N+2. Accept-to-response latency is 2 cycles.
- Writes complete at the grant edge and produce no response.
- Read in the cycle after a write to the same address returns the new data (memory ordering, single port). Requests are served in grant order.
- Response FIFO:
  - 2 entries, first-word-fall-through from registers; rdata is stable while valid && !ready.
  - Simultaneous push and pop is allowed.
  - Overflow is impossible by construction; an assertion flags it.
- A request with valid low must not be granted. Requester inputs must hold while valid && !ready.

Decomposition:
- Shared package mem_arb_pkg:
  - port id typedef (1 bit);
  - PRIO_RR / PRIO_FIXED constants;
  - request struct {addr, wdata, wen}.
- Sub-module mem_rsp_fifo: 2-entry, parameterised by DATA_WIDTH, with push/pop/count/valid. Instantiated once per port.

Test Plan:
- Write then read, single port. p1 writes 0xDEADBEEF to addr 0x005 with wen=4'hF, then reads 0x005 → rsp_valid on p1 two cycles after the read grant, rdata=0xDEADBEEF; p0 sees no response.
- Byte write. Write 0x11223344 to 0x7FF, then wen=4'b0100 with data 0x00AA0000 → read returns 0x11AA3344.
- Round-robin conflict. Both ports hold reads every cycle (p0 addr 0x010, p1 addr 0x020), rsp_ready=1 → grants alternate p0,p1,p0,…; each port gets a response every 2 cycles with the correct data.
- Backpressure. p0 issues back-to-back reads to 0x000–0x003 with i_p0_rsp_ready=0 → exactly 2 accepted, then req_ready=0. Raising ready drains data in order, and acceptance resumes with no loss.
- Fixed priority. PRIO_MODE=1, both ports request continuously → p1 is granted every cycle and p0 is never granted until p1 deasserts.
- Reset mid-read. Assert rst_n low the cycle after a read grant → no rsp_valid is ever issued for it. After release, the first contested grant goes to p0.
